// File: rtl/placement_pkg.sv
// Constants and FSM state type shared by the placer and the placement evaluator.
package placement_pkg;
  localparam int N_EDGE = 15;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int GRID_N = 16;
  localparam logic signed [DATA_W-1:0] POS_INVALID = -1;

  typedef enum logic [2:0] {
    IDLE,
    RD_E,
    RD_A,
    RD_B,
    ACC,
    FIN
  } eval_state_e;
endpackage

// File: rtl/placement_eval_manhattan_dist.sv
// Manhattan distance between two grid points, plus a check that all four
// coordinates lie on the grid.
module manhattan_dist
  import placement_pkg::*;
(
  input  logic signed [DATA_W-1:0] ax_i,
  input  logic signed [DATA_W-1:0] ay_i,
  input  logic signed [DATA_W-1:0] bx_i,
  input  logic signed [DATA_W-1:0] by_i,
  output logic        [DATA_W-1:0] d_o,
  output logic                     in_range_o
);
  logic signed [DATA_W:0] dx, dy, dx_abs, dy_abs, sum;

  function automatic logic coord_ok(input logic signed [DATA_W-1:0] v);
    return (v >= 0) && (v < GRID_N);
  endfunction

  // One extra bit so the difference of two extreme values cannot wrap.
  always_comb begin
    dx     = {ax_i[DATA_W-1], ax_i} - {bx_i[DATA_W-1], bx_i};
    dy     = {ay_i[DATA_W-1], ay_i} - {by_i[DATA_W-1], by_i};
    dx_abs = dx[DATA_W] ? -dx : dx;
    dy_abs = dy[DATA_W] ? -dy : dy;
    sum    = dx_abs + dy_abs;
    d_o    = sum[DATA_W-1:0];
    in_range_o = coord_ok(ax_i) && coord_ok(ay_i) && coord_ok(bx_i) && coord_ok(by_i);
  end
endmodule

// File: rtl/placement_eval.sv
// Post-placement evaluator: walks the edge list and final node positions and
// reports total wirelength cost, longest edge and integrity flags.
module placement_eval
  import placement_pkg::*;
#(
  parameter int NUM_EDGES = N_EDGE
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic signed [DATA_W-1:0] cost_o,
  output logic        [DATA_W-1:0] max_len_o,
  output logic                     invalid_o,
  output logic                     overlap_o,
  output logic                     e_re_o,
  output logic        [ADDR_W-1:0] e_addr_o,
  input  logic        [DATA_W-1:0] ea_data_i,
  input  logic        [DATA_W-1:0] eb_data_i,
  output logic                     pos_re_o,
  output logic        [ADDR_W-1:0] pos_addr_o,
  input  logic signed [DATA_W-1:0] px_data_i,
  input  logic signed [DATA_W-1:0] py_data_i
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_EDGES - 1);

  eval_state_e              state_q;
  logic        [ADDR_W-1:0] idx_q, b_q;
  logic signed [DATA_W-1:0] ax_q, ay_q, cost_q;
  logic        [DATA_W-1:0] max_len_q, dist_d;
  logic                     busy_q, done_q, invalid_q, overlap_q, in_range_d;
  logic                     unused_bits;

  // Node indices are only ADDR_W wide; upper ROM bits are ignored.
  assign unused_bits = ^{ea_data_i[DATA_W-1:ADDR_W], eb_data_i[DATA_W-1:ADDR_W]};

  manhattan_dist u_dist (
    .ax_i      (ax_q),
    .ay_i      (ay_q),
    .bx_i      (px_data_i),
    .by_i      (py_data_i),
    .d_o       (dist_d),
    .in_range_o(in_range_d)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      b_q       <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      cost_q    <= '0;
      max_len_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cost_q    <= '0;
            max_len_q <= '0;
            invalid_q <= 1'b0;
            overlap_q <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= RD_E;
          end
        end
        RD_E: state_q <= RD_A;
        RD_A: begin
          b_q     <= eb_data_i[ADDR_W-1:0];
          state_q <= RD_B;
        end
        RD_B: begin
          ax_q    <= px_data_i;
          ay_q    <= py_data_i;
          state_q <= ACC;
        end
        ACC: begin
          if (!in_range_d) begin
            invalid_q <= 1'b1;
          end else begin
            cost_q <= cost_q + $signed(dist_d) - DATA_W'(1);
            if (dist_d > max_len_q) max_len_q <= dist_d;
            if (dist_d == '0) overlap_q <= 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= RD_E;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read strobes follow the state directly; the A-node address comes straight
  // from the edge ROM output in the cycle it becomes valid.
  assign e_re_o     = (state_q == RD_E);
  assign e_addr_o   = idx_q;
  assign pos_re_o   = (state_q == RD_A) || (state_q == RD_B);
  assign pos_addr_o = (state_q == RD_A) ? ea_data_i[ADDR_W-1:0] :
                      (state_q == RD_B) ? b_q : '0;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cost_o    = cost_q;
  assign max_len_o = max_len_q;
  assign invalid_o = invalid_q;
  assign overlap_o = overlap_q;
endmodule

// File: tb/tb_placement_eval.sv
// Bench for placement_eval: three instances (15, 3 and 1 edges) with ROM/RAM
// models, a per-cycle comparison against a behavioural model, plus literal checks.
module tb_placement_eval;
  localparam int NE [3] = '{15, 3, 1};
  localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start [3];
  logic busy [3], done [3], invalid [3], overlap [3], e_re [3], pos_re [3];
  logic signed [31:0] cost [3];
  logic [31:0] max_len [3];
  logic [3:0] e_addr [3], pos_addr [3];
  logic [31:0] ea_d [3], eb_d [3];
  logic signed [31:0] px_d [3], py_d [3];

  logic [31:0] ea_rom [3][16], eb_rom [3][16];
  int px_ram [3][16], py_ram [3][16];

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  bit active [3] = '{0, 0, 0};
  int scyc [3] = '{0, 0, 0};
  bit res_valid [3] = '{1, 1, 1};
  longint exp_cost [3] = '{0, 0, 0};
  longint exp_max [3] = '{0, 0, 0};
  bit exp_inv [3] = '{0, 0, 0};
  bit exp_ovl [3] = '{0, 0, 0};
  longint p_cost [3], p_max [3];
  bit p_inv [3], p_ovl [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    placement_eval #(.NUM_EDGES(NE[g])) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start[g]),
      .busy_o(busy[g]), .done_o(done[g]), .cost_o(cost[g]), .max_len_o(max_len[g]),
      .invalid_o(invalid[g]), .overlap_o(overlap[g]),
      .e_re_o(e_re[g]), .e_addr_o(e_addr[g]), .ea_data_i(ea_d[g]), .eb_data_i(eb_d[g]),
      .pos_re_o(pos_re[g]), .pos_addr_o(pos_addr[g]), .px_data_i(px_d[g]), .py_data_i(py_d[g])
    );
  end

  // Synchronous-read memories; junk when not enabled exposes mistimed sampling.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (e_re[k]) begin
        ea_d[k] <= ea_rom[k][e_addr[k]];
        eb_d[k] <= eb_rom[k][e_addr[k]];
      end else begin
        ea_d[k] <= JUNK;
        eb_d[k] <= JUNK;
      end
      if (pos_re[k]) begin
        px_d[k] <= px_ram[k][pos_addr[k]];
        py_d[k] <= py_ram[k][pos_addr[k]];
      end else begin
        px_d[k] <= JUNK;
        py_d[k] <= JUNK;
      end
    end
  end

  function automatic void chk(input string nm, input int k, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endfunction

  // Reference evaluation straight from the edge list and positions.
  function automatic void evaluate(input int k, output longint c, output longint m,
                                   output bit inv, output bit ovl);
    c = 0; m = 0; inv = 0; ovl = 0;
    for (int e = 0; e < NE[k]; e++) begin
      int na, nb;
      longint ax, ay, bx, by, d;
      na = int'(ea_rom[k][e] & 32'hF);
      nb = int'(eb_rom[k][e] & 32'hF);
      ax = px_ram[k][na]; ay = py_ram[k][na];
      bx = px_ram[k][nb]; by = py_ram[k][nb];
      if (ax < 0 || ax > 15 || ay < 0 || ay > 15 || bx < 0 || bx > 15 || by < 0 || by > 15) begin
        inv = 1;
      end else begin
        d = (ax > bx ? ax - bx : bx - ax) + (ay > by ? ay - by : by - ay);
        c += d - 1;
        if (d > m) m = d;
        if (d == 0) ovl = 1;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        active[k] = 0; res_valid[k] = 1;
        exp_cost[k] = 0; exp_max[k] = 0; exp_inv[k] = 0; exp_ovl[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (start[k] && (!active[k] || (cyc - scyc[k]) >= 4 * NE[k] + 2)) begin
          active[k] = 1;
          scyc[k] = cyc;
          res_valid[k] = 0;
          evaluate(k, p_cost[k], p_max[k], p_inv[k], p_ovl[k]);
        end
        if (active[k] && !res_valid[k] && (cyc - scyc[k]) == 4 * NE[k]) begin
          exp_cost[k] = p_cost[k]; exp_max[k] = p_max[k];
          exp_inv[k] = p_inv[k]; exp_ovl[k] = p_ovl[k];
          res_valid[k] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int rel, ph, node;
      bit run, x_ere, x_pre;
      if (!rst_n) begin
        chk("rst_busy", k, busy[k], 0);
        chk("rst_done", k, done[k], 0);
        chk("rst_cost", k, cost[k], 0);
        chk("rst_e_re", k, e_re[k], 0);
      end else begin
        rel = cyc - scyc[k];
        ph = rel % 4;
        run = active[k] && rel <= 4 * NE[k];
        x_ere = run && rel < 4 * NE[k] && ph == 0;
        x_pre = run && rel < 4 * NE[k] && (ph == 1 || ph == 2);
        chk("busy", k, busy[k], run);
        chk("done", k, done[k], active[k] && rel == 4 * NE[k]);
        chk("e_re", k, e_re[k], x_ere);
        chk("pos_re", k, pos_re[k], x_pre);
        if (x_ere) chk("e_addr", k, e_addr[k], rel / 4);
        if (x_pre) begin
          node = int'((ph == 1 ? ea_rom[k][rel / 4] : eb_rom[k][rel / 4]) & 32'hF);
          chk("pos_addr", k, pos_addr[k], node);
        end
        if (res_valid[k]) begin
          chk("cost", k, cost[k], exp_cost[k]);
          chk("max_len", k, max_len[k], exp_max[k]);
          chk("invalid", k, invalid[k], exp_inv[k]);
          chk("overlap", k, overlap[k], exp_ovl[k]);
        end
      end
    end
  end

  task automatic set_e(input int k, input int e, input logic [31:0] a, input logic [31:0] b);
    ea_rom[k][e] = a;
    eb_rom[k][e] = b;
  endtask

  task automatic set_p(input int k, input int n, input int x, input int y);
    px_ram[k][n] = x;
    py_ram[k][n] = y;
  endtask

  task automatic pulse_start(input int k);
    @(posedge clk); #2; start[k] = 1'b1;
    @(posedge clk); #2; start[k] = 1'b0;
  endtask

  // Returns the cycle (start-acceptance cycle = 0) at which done is seen, or -1.
  task automatic run_wait(input int k, output int dc);
    dc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done[k]) begin
        dc = n;
        break;
      end
    end
  endtask

  task automatic run_test(input int k, input string nm, input int x_dc, input longint x_cost,
                          input longint x_max, input bit x_inv, input bit x_ovl);
    int dc;
    pulse_start(k);
    run_wait(k, dc);
    chk({nm, "_done_cycle"}, k, dc, x_dc);
    chk({nm, "_cost"}, k, cost[k], x_cost);
    chk({nm, "_max_len"}, k, max_len[k], x_max);
    chk({nm, "_invalid"}, k, invalid[k], x_inv);
    chk({nm, "_overlap"}, k, overlap[k], x_ovl);
  endtask

  initial begin
    int dc, ndone;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        set_e(k, i, 0, 0);
        set_p(k, i, 0, 0);
      end
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", k, busy[k], 0);
      chk("reset_cost", k, cost[k], 0);
      chk("reset_max_len", k, max_len[k], 0);
      chk("reset_pos_re", k, pos_re[k], 0);
    end

    // Chain 0-1-2-3, unit steps.
    set_e(1, 0, 0, 1); set_e(1, 1, 1, 2); set_e(1, 2, 2, 3);
    set_p(1, 0, 0, 0); set_p(1, 1, 0, 1); set_p(1, 2, 0, 2); set_p(1, 3, 1, 2);
    run_test(1, "chain", 13, 0, 1, 0, 0);

    // Single edge (0,0)-(3,2).
    set_e(2, 0, 0, 1);
    set_p(2, 0, 0, 0); set_p(2, 1, 3, 2);
    run_test(2, "single", 5, 4, 5, 0, 0);

    // Node 2 has x=-1 on edge 1; edges 0 and 2 contribute d=3 and d=7.
    set_e(1, 0, 0, 1); set_e(1, 1, 2, 3); set_e(1, 2, 4, 5);
    set_p(1, 0, 0, 0); set_p(1, 1, 2, 1); set_p(1, 2, -1, 0);
    set_p(1, 3, 5, 5); set_p(1, 4, 1, 1); set_p(1, 5, 4, 5);
    run_test(1, "neg_coord", 13, 8, 7, 1, 0);

    // Nodes 0 and 1 coincide at (2,2): d = 0, 3, 8.
    set_e(1, 0, 0, 1); set_e(1, 1, 1, 2); set_e(1, 2, 2, 3);
    set_p(1, 0, 2, 2); set_p(1, 1, 2, 2); set_p(1, 2, 5, 2); set_p(1, 3, 5, 10);
    run_test(1, "overlap", 13, 8, 8, 0, 1);

    // Grid corners, x=GRID_N on node 2, and node indices with upper bits set.
    set_e(1, 0, 0, 1); set_e(1, 1, 0, 2); set_e(1, 2, 32'h13, 32'h24);
    set_p(1, 0, 15, 15); set_p(1, 1, 0, 0); set_p(1, 2, 16, 0);
    set_p(1, 3, 7, 7); set_p(1, 4, 7, 8);
    run_test(1, "range_trunc", 13, 29, 30, 1, 0);

    // 15-edge chain: x = 3j mod 16, y = 5j mod 16 -> cost 149, max 18.
    for (int i = 0; i < 15; i++) set_e(0, i, i, i + 1);
    for (int j = 0; j < 16; j++) set_p(0, j, (3 * j) % 16, (5 * j) % 16);

    pulse_start(0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 0, busy[0], 0);
    chk("midreset_cost", 0, cost[0], 0);
    run_test(0, "restart", 61, 149, 18, 0, 0);

    // Extra starts at cycles 5 and 61 are ignored; the one at 62 launches a new run.
    pulse_start(0);
    dc = -1;
    ndone = 0;
    for (int s = 1; s <= 62; s++) begin
      start[0] = (s == 5 || s == 61 || s == 62);
      @(negedge clk);
      if (done[0]) begin
        ndone++;
        if (dc < 0) dc = s;
      end
      @(posedge clk); #2;
    end
    start[0] = 1'b0;
    chk("busy_start_done_cycle", 0, dc, 61);
    chk("busy_start_done_count", 0, ndone, 1);
    run_wait(0, dc);
    chk("relaunch_done_cycle", 0, dc, 61);
    chk("relaunch_cost", 0, cost[0], 149);
    chk("relaunch_max_len", 0, max_len[0], 18);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
